// File: rtl/booth_iter_counter.sv
// Iteration counter/sequencer for multi-cycle datapaths (Booth multiplier,
// shift-add divider). Loads INIT or ld_val on start, counts down on dec and
// reports busy, last, eqz and a one-cycle done through a start/done handshake.
// Optional macro BOOTH_ITER_RADIX4_EN adds a step2 input for decrement-by-2 steps.
module booth_iter_counter #(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned INIT  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             ld_sel,
  input  logic [WIDTH-1:0] ld_val,
  input  logic             dec,
`ifdef BOOTH_ITER_RADIX4_EN
  input  logic             step2,
`endif
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             eqz,
  output logic             last,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] step_amt;
  logic             use_step2;
  logic             final_step;

`ifdef BOOTH_ITER_RADIX4_EN
  assign use_step2 = step2;
`else
  assign use_step2 = 1'b0;
`endif

  // Load value, step size and whether a dec this cycle ends the run.
  always_comb begin
    load_val   = ld_sel ? ld_val : WIDTH'(INIT);
    step_amt   = use_step2 ? WIDTH'(2) : WIDTH'(1);
    // Radix-4 steps saturate at 0, so an odd count still finishes cleanly.
    final_step = use_step2 ? (count_q <= WIDTH'(2)) : (count_q == WIDTH'(1));
  end

  // Next-state and next-count decode; abort outranks dec, start ignored in RUN.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          count_d = load_val;
          state_d = (load_val != '0) ? StRun : StDone;
        end
      end
      StRun: begin
        if (abort) begin
          count_d = '0;
          state_d = StIdle;
        end else if (dec) begin
          if (final_step) begin
            count_d = '0;
            state_d = StDone;
          end else begin
            count_d = count_q - step_amt;
          end
        end
      end
      StDone: begin
        // Back-to-back start avoids an idle bubble between runs.
        if (start) begin
          count_d = load_val;
          state_d = (load_val != '0) ? StRun : StDone;
        end else begin
          count_d = '0;
          state_d = StIdle;
        end
      end
      default: begin
        count_d = '0;
        state_d = StIdle;
      end
    endcase
  end

  // State and count registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Outputs decode registered state/count only (last also sees step2).
  always_comb begin
    count = count_q;
    eqz   = (count_q == '0);
    busy  = (state_q == StRun);
    done  = (state_q == StDone);
    last  = busy & final_step;
  end

endmodule

// File: tb/tb_booth_iter_counter.sv
// Self-checking bench for booth_iter_counter: a behavioural model pushes the
// expected post-edge outputs to a scoreboard queue as each cycle is driven,
// and they are popped and compared after the clock edge.
module tb_booth_iter_counter;

  localparam int unsigned W    = 6;
  localparam int unsigned INIT = 32;
`ifdef BOOTH_ITER_RADIX4_EN
  localparam bit R4 = 1'b1;
`else
  localparam bit R4 = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0, ld_sel = 1'b0, dec = 1'b0, abort = 1'b0, step2 = 1'b0;
  logic [W-1:0] ld_val = '0;
  logic [W-1:0] count;
  logic         eqz, last, busy, done;

  booth_iter_counter #(.WIDTH(W), .INIT(INIT)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .ld_sel (ld_sel),
    .ld_val (ld_val),
    .dec    (dec),
`ifdef BOOTH_ITER_RADIX4_EN
    .step2  (step2),
`endif
    .abort  (abort),
    .count  (count),
    .eqz    (eqz),
    .last   (last),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] count;
    logic         eqz;
    logic         last;
    logic         busy;
    logic         done;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   m_state  = 0;  // 0 idle, 1 run, 2 done
  int   m_count  = 0;
  int   done_seen;
  int   cyc;
  int   done_cyc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d expected=%0d @%0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle, advance the model, compare after the edge.
  task automatic step(input logic st, input logic ls, input logic [W-1:0] lv,
                      input logic dc, input logic ab, input logic s2);
    exp_t e;
    int   ld;
    int   amt;
    start = st; ld_sel = ls; ld_val = lv; dec = dc; abort = ab; step2 = s2;
    ld = ls ? int'(lv) : int'(INIT);
    if (m_state == 0 || m_state == 2) begin
      if (st) begin
        m_count = ld;
        m_state = (ld != 0) ? 1 : 2;
      end else begin
        m_count = 0;
        m_state = 0;
      end
    end else if (ab) begin
      m_count = 0;
      m_state = 0;
    end else if (dc) begin
      amt = (R4 && s2) ? 2 : 1;
      if (m_count <= amt) begin
        m_count = 0;
        m_state = 2;
      end else begin
        m_count = m_count - amt;
      end
    end
    e.count = W'(m_count);
    e.eqz   = (m_count == 0);
    e.busy  = (m_state == 1);
    e.done  = (m_state == 2);
    e.last  = (m_state == 1) && ((R4 && s2) ? (m_count <= 2) : (m_count == 1));
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check("count", 32'(count), 32'(e.count));
    check("eqz", 32'(eqz), 32'(e.eqz));
    check("last", 32'(last), 32'(e.last));
    check("busy", 32'(busy), 32'(e.busy));
    check("done", 32'(done), 32'(e.done));
    if (done === 1'b1) done_seen++;
  endtask

  initial begin
    // Power-on reset, released away from a clock edge.
    #12 rst = 1'b0;
    #1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_eqz", 32'(eqz), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    @(posedge clk); #1;

    // Mid-run async reset at count=17.
    step(1, 1, 6'd20, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 0);
    check("pre_rst_count", 32'(count), 32'd17);
    #1 rst = 1'b1;
    #1;
    check("arst_count", 32'(count), 32'd0);
    check("arst_eqz", 32'(eqz), 32'd1);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_last", 32'(last), 32'd0);
    #1 rst = 1'b0;
    m_state = 0;
    m_count = 0;
    step(0, 0, 0, 1, 0, 0);

    // Default load of INIT, dec held high; done 33 cycles after start.
    done_seen = 0;
    done_cyc  = -1;
    step(1, 0, 6'd9, 1, 0, 0);
    cyc = 1;
    for (int i = 0; i < 34; i++) begin
      step(0, 0, 0, 1, 0, 0);
      cyc++;
      if (done === 1'b1 && done_cyc < 0) done_cyc = cyc;
    end
    check("init_done_pulses", 32'(done_seen), 32'd1);
    check("init_done_cycle", 32'(done_cyc), 32'd33);

    // Zero load: straight to DONE, never busy.
    done_seen = 0;
    step(1, 1, 6'd0, 0, 0, 0);
    check("zero_busy", 32'(busy), 32'd0);
    step(0, 0, 0, 0, 0, 0);
    check("zero_done_pulses", 32'(done_seen), 32'd1);

    // ld_val=5, dec toggling, stray starts during RUN.
    done_seen = 0;
    step(1, 1, 6'd5, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(i % 3 == 1, 1, 6'd7, i % 2 == 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check("toggle_done_pulses", 32'(done_seen), 32'd1);

    // Abort wins over dec: no done pulse.
    done_seen = 0;
    step(1, 1, 6'd10, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 1, 0, 0);
    check("abort_done_pulses", 32'(done_seen), 32'd0);

    // Back-to-back start in the DONE cycle.
    step(1, 1, 6'd2, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    check("b2b_in_done", 32'(done), 32'd1);
    step(1, 1, 6'd3, 0, 0, 0);
    check("b2b_busy", 32'(busy), 32'd1);
    check("b2b_count", 32'(count), 32'd3);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0, 0);

    // Radix-4 stepping (step2 only reaches the DUT when the macro is set).
    done_seen = 0;
    step(1, 1, 6'd5, 0, 0, 1);
    for (int i = 0; i < 7; i++) step(0, 0, 0, 1, 0, 1);
    check("r4_done_pulses", 32'(done_seen), 32'd1);
    step(1, 1, 6'd4, 1, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 0, i % 2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/booth_iter_counter.md
Name: booth_iter_counter

Overview:
- Parametrised iteration counter/sequencer for multi-cycle datapaths (Booth multiplier, shift-add divider).
- Loads a default or programmable iteration count on start and decrements on each datapath step.
- Provides zero, last-iteration, busy and one-cycle done indications through a start/done handshake.
- Successor to the fixed 6-bit load-32 down counter: generalised width and load value, plus sequencing, abort and an optional radix-4 step.

Parameters:
- WIDTH, 6, counter width in bits.
- INIT, 32, default load value used when ld_sel=0; must satisfy INIT <= 2^WIDTH-1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request a new iteration run
- ld_sel  input  1  1: load ld_val; 0: load INIT (sampled with start)
- ld_val  input  WIDTH  programmable iteration count
- dec  input  1  datapath completed one step this cycle
- abort  input  1  cancel the run in progress
- count  output  WIDTH  remaining iterations (registered)
- eqz  output  1  count==0 (combinational from count)
- last  output  1  busy and the next dec finishes the run
- busy  output  1  state==RUN
- done  output  1  one-cycle pulse, state==DONE

Behaviour:
- Reset (async, any time including mid-run): state=IDLE, count=0. Outputs: eqz=1, last=0, busy=0, done=0.
- Registered state and count; busy and done decode the registered state, giving no combinational path from inputs.
- IDLE:
  - start=1: count <= (ld_sel ? ld_val : INIT).
  - Next state is RUN if the loaded value is nonzero, else DONE.
  - dec and abort are ignored.
- RUN:
  - Priority order: abort > dec. start is ignored.
  - abort=1: count <= 0, next IDLE, no done pulse.
  - dec=1 and count>1: count <= count-1.
  - dec=1 and count==1: count <= 0, next DONE.
  - dec=0: count holds.
- DONE (exactly one cycle): done=1, count=0.
  - start=1: accepted back-to-back with the same load and next-state rule as IDLE.
  - Otherwise next IDLE. abort and dec are ignored.
- last = busy & (count==1) in step-1 mode. It lets the datapath perform its final step in the same cycle.
- Latency:
  - start to busy: 1 cycle.
  - N=count loaded, dec held high: done rises N+1 cycles after start is sampled.
  - A zero load gives done 1 cycle after start.
- Arithmetic: count is unsigned and never wraps below 0. ld_val is taken as-is (full WIDTH range).

Optional Feature:
- Macro: BOOTH_ITER_RADIX4_EN.
- Defined:
  - Adds input port step2 (1 bit, after dec).
  - In RUN, dec & step2 decrements by 2.
  - If count<=2 on that step: count <= 0, next DONE (odd counts saturate at 0).
  - last = busy & (step2 ? count<=2 : count==1).
  - dec & ~step2 behaves as step-1.
- Undefined: no step2 port; step-1 only; behaviour exactly as above.

Test Plan:
- Assert rst mid-run with count=17 -> immediately count=0, eqz=1, busy=0, done=0; the first clock after release leaves state IDLE.
- start, ld_sel=0, dec held 1 -> count 32,31,…,1,0; last high when count=1; done pulses once, 33 cycles after start; then IDLE.
- start, ld_sel=1, ld_val=0 -> busy never asserts; done=1 the next cycle; count=0.
- ld_val=5, dec toggled 1,0,1,0… plus start pulses during RUN -> count steps only on dec cycles; extra starts are ignored; done after 5 dec cycles.
- ld_val=10, abort after 3 decs with dec=1 in the same cycle -> count=0, IDLE next cycle, no done pulse.
- start asserted in the DONE cycle with ld_val=3 -> busy the next cycle with count=3 and no idle gap. With BOOTH_ITER_RADIX4_EN, ld_val=5, step2=1 -> count 5,3,1,0; done pulses once.
